// File: rtl/space_wire_supervisor_pkg.sv
// Shared types and helpers for the SpaceWire link supervisor: state codes,
// register widths and the saturating exponential backoff length.
package space_wire_supervisor_pkg;

  localparam int unsigned STATE_W     = 3;
  localparam int unsigned RETRY_W     = 3;
  localparam int unsigned ERR_W       = 8;
  localparam int unsigned CNT_W       = 8;
  localparam int unsigned MAX_TIMER_W = 32;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE    = 3'd0,
    ST_START   = 3'd1,
    ST_RUN     = 3'd2,
    ST_BACKOFF = 3'd3,
    ST_FAILED  = 3'd4
  } chan_state_e;

  // base << retry, computed 7 bits wider than the timer, then clamped to
  // the largest value a timer_w-bit timer can hold.
  function automatic logic [MAX_TIMER_W-1:0] backoff_len(
    input logic [MAX_TIMER_W-1:0] base,
    input logic [RETRY_W-1:0]     retry,
    input int unsigned            timer_w
  );
    logic [MAX_TIMER_W+6:0] shifted;
    logic [MAX_TIMER_W+6:0] limit;
    shifted = {7'd0, base} << retry;
    limit   = ((MAX_TIMER_W+7)'(1) << timer_w) - (MAX_TIMER_W+7)'(1);
    if (shifted > limit) begin
      shifted = limit;
    end
    return shifted[MAX_TIMER_W-1:0];
  endfunction

endpackage

// File: rtl/space_wire_link_supervisor_chan.sv
// One supervised link: start/retry FSM with down-counting timer, retry
// counter, sticky error flags and a saturating link-drop counter.
module space_wire_link_supervisor_chan
  import space_wire_supervisor_pkg::*;
#(
  parameter int unsigned          C_TIMER_W           = 16,
  parameter logic [C_TIMER_W-1:0] C_START_TIMEOUT_VAL = 16'd2000,
  parameter logic [C_TIMER_W-1:0] C_BACKOFF_BASE_VAL  = 16'd640,
  parameter logic [RETRY_W-1:0]   C_MAX_RETRY         = 3'd5
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_enable,
  input  logic               i_link_run,
  input  logic [ERR_W-1:0]   i_error_status,
  input  logic [ERR_W-1:0]   i_err_clear,
  input  logic [ERR_W-1:0]   i_err_irq_mask,
  input  logic               i_stat_clear,
  output logic               o_link_start,
  output logic               o_link_disable,
  output logic [STATE_W-1:0] o_state,
  output logic [RETRY_W-1:0] o_retry,
  output logic [ERR_W-1:0]   o_err_sticky,
  output logic [CNT_W-1:0]   o_link_down_cnt,
  output logic               o_irq_req
);

  localparam logic [C_TIMER_W-1:0] T_ONE      = C_TIMER_W'(1);
  localparam logic [C_TIMER_W-1:0] START_LOAD = C_START_TIMEOUT_VAL - T_ONE;
  localparam logic [CNT_W-1:0]     CNT_MAX    = {CNT_W{1'b1}};

  chan_state_e          state_q, state_d;
  logic [C_TIMER_W-1:0] timer_q, timer_d;
  logic [RETRY_W-1:0]   retry_q, retry_d;
  logic [ERR_W-1:0]     sticky_q, sticky_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [C_TIMER_W-1:0] bo_len;
  logic                 timer_expired;
  logic                 retry_step;
  logic                 drop;

  always_comb begin
    state_d       = state_q;
    timer_d       = timer_q;
    retry_d       = retry_q;
    retry_step    = 1'b0;
    drop          = 1'b0;
    timer_expired = (timer_q == '0);
    bo_len        = C_TIMER_W'(backoff_len(MAX_TIMER_W'(C_BACKOFF_BASE_VAL), retry_q, C_TIMER_W));

    if (!i_enable) begin
      state_d = ST_IDLE;
      retry_d = '0;
      timer_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_START;
          retry_d = '0;
          timer_d = START_LOAD;
        end
        ST_START: begin
          // A run indication wins over a coincident timeout.
          if (i_link_run) begin
            state_d = ST_RUN;
            retry_d = '0;
          end else if (timer_expired) begin
            retry_step = 1'b1;
          end else begin
            timer_d = timer_q - T_ONE;
          end
        end
        ST_RUN: begin
          if (!i_link_run) begin
            drop       = 1'b1;
            retry_step = 1'b1;
          end
        end
        ST_BACKOFF: begin
          if (timer_expired) begin
            state_d = ST_START;
            timer_d = START_LOAD;
          end else begin
            timer_d = timer_q - T_ONE;
          end
        end
        ST_FAILED: begin
          state_d = ST_FAILED;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase

      if (retry_step) begin
        if (retry_q == C_MAX_RETRY) begin
          state_d = ST_FAILED;
        end else begin
          state_d = ST_BACKOFF;
          timer_d = bo_len - T_ONE;
          retry_d = retry_q + 1'b1;
        end
      end
    end
  end

  // Set beats clear for the sticky flags; a drop beats stat_clear for the count.
  always_comb begin
    sticky_d = (sticky_q & ~i_err_clear) | i_error_status;
    cnt_d    = i_stat_clear ? '0 : cnt_q;
    if (drop && (cnt_d != CNT_MAX)) begin
      cnt_d = cnt_d + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q  <= ST_IDLE;
      timer_q  <= '0;
      retry_q  <= '0;
      sticky_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      retry_q  <= retry_d;
      sticky_q <= sticky_d;
      cnt_q    <= cnt_d;
    end
  end

  assign o_link_start    = (state_q == ST_START) || (state_q == ST_RUN);
  assign o_link_disable  = (state_q == ST_IDLE) || (state_q == ST_BACKOFF) || (state_q == ST_FAILED);
  assign o_state         = state_q;
  assign o_retry         = retry_q;
  assign o_err_sticky    = sticky_q;
  assign o_link_down_cnt = cnt_q;
  assign o_irq_req       = (|(sticky_q & i_err_irq_mask)) || (state_q == ST_FAILED);

endmodule

// File: rtl/space_wire_link_supervisor.sv
// N-channel SpaceWire link supervisor: one channel engine per link plus a
// registered interrupt reduced across all channels.
module space_wire_link_supervisor
  import space_wire_supervisor_pkg::*;
#(
  parameter int unsigned          C_CHANNELS          = 4,
  parameter int unsigned          C_TIMER_W           = 16,
  parameter logic [C_TIMER_W-1:0] C_START_TIMEOUT_VAL = 16'd2000,
  parameter logic [C_TIMER_W-1:0] C_BACKOFF_BASE_VAL  = 16'd640,
  parameter logic [RETRY_W-1:0]   C_MAX_RETRY         = 3'd5
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  input  logic [C_CHANNELS-1:0]         i_enable,
  input  logic [C_CHANNELS-1:0]         i_link_run,
  input  logic [ERR_W*C_CHANNELS-1:0]   i_error_status,
  input  logic [ERR_W*C_CHANNELS-1:0]   i_err_clear,
  input  logic [ERR_W-1:0]              i_err_irq_mask,
  input  logic                          i_stat_clear,
  output logic [C_CHANNELS-1:0]         o_link_start,
  output logic [C_CHANNELS-1:0]         o_link_disable,
  output logic [STATE_W*C_CHANNELS-1:0] o_chan_state,
  output logic [RETRY_W*C_CHANNELS-1:0] o_retry_count,
  output logic [ERR_W*C_CHANNELS-1:0]   o_err_sticky,
  output logic [CNT_W*C_CHANNELS-1:0]   o_link_down_cnt,
  output logic                          o_irq
);

  logic [C_CHANNELS-1:0] irq_req;
  logic                  irq_q, irq_d;

  for (genvar k = 0; k < C_CHANNELS; k++) begin : g_chan
    space_wire_link_supervisor_chan #(
      .C_TIMER_W          (C_TIMER_W),
      .C_START_TIMEOUT_VAL(C_START_TIMEOUT_VAL),
      .C_BACKOFF_BASE_VAL (C_BACKOFF_BASE_VAL),
      .C_MAX_RETRY        (C_MAX_RETRY)
    ) u_chan (
      .i_clk          (i_clk),
      .i_reset        (i_reset),
      .i_enable       (i_enable[k]),
      .i_link_run     (i_link_run[k]),
      .i_error_status (i_error_status[ERR_W*k +: ERR_W]),
      .i_err_clear    (i_err_clear[ERR_W*k +: ERR_W]),
      .i_err_irq_mask (i_err_irq_mask),
      .i_stat_clear   (i_stat_clear),
      .o_link_start   (o_link_start[k]),
      .o_link_disable (o_link_disable[k]),
      .o_state        (o_chan_state[STATE_W*k +: STATE_W]),
      .o_retry        (o_retry_count[RETRY_W*k +: RETRY_W]),
      .o_err_sticky   (o_err_sticky[ERR_W*k +: ERR_W]),
      .o_link_down_cnt(o_link_down_cnt[CNT_W*k +: CNT_W]),
      .o_irq_req      (irq_req[k])
    );
  end

  always_comb begin
    irq_d = |irq_req;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= irq_d;
    end
  end

  assign o_irq = irq_q;

endmodule

// File: tb/tb_space_wire_link_supervisor.sv
// Directed bench for space_wire_link_supervisor: a 4-channel instance with
// short timers and a 1-channel 8-bit-timer instance for backoff saturation.
module tb_space_wire_link_supervisor;

  localparam int CH = 4;

  logic clk = 1'b0;
  logic rst;

  logic [CH-1:0]   enable, link_run;
  logic [8*CH-1:0] err_status, err_clear;
  logic [7:0]      err_mask;
  logic            stat_clear;
  logic [CH-1:0]   link_start, link_disable;
  logic [3*CH-1:0] chan_state, retry_count;
  logic [8*CH-1:0] err_sticky, link_down_cnt;
  logic            irq;

  logic       s_enable, s_run, s_stat_clear;
  logic [7:0] s_err_status, s_err_clear;
  logic       s_link_start, s_link_disable, s_irq;
  logic [2:0] s_state, s_retry;
  logic [7:0] s_sticky, s_cnt;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  space_wire_link_supervisor #(
    .C_CHANNELS(CH), .C_TIMER_W(16), .C_START_TIMEOUT_VAL(16'd20),
    .C_BACKOFF_BASE_VAL(16'd8), .C_MAX_RETRY(3'd2)
  ) u_dut (
    .i_clk(clk), .i_reset(rst), .i_enable(enable), .i_link_run(link_run),
    .i_error_status(err_status), .i_err_clear(err_clear), .i_err_irq_mask(err_mask),
    .i_stat_clear(stat_clear), .o_link_start(link_start), .o_link_disable(link_disable),
    .o_chan_state(chan_state), .o_retry_count(retry_count), .o_err_sticky(err_sticky),
    .o_link_down_cnt(link_down_cnt), .o_irq(irq)
  );

  space_wire_link_supervisor #(
    .C_CHANNELS(1), .C_TIMER_W(8), .C_START_TIMEOUT_VAL(8'd4),
    .C_BACKOFF_BASE_VAL(8'd100), .C_MAX_RETRY(3'd3)
  ) u_sat (
    .i_clk(clk), .i_reset(rst), .i_enable(s_enable), .i_link_run(s_run),
    .i_error_status(s_err_status), .i_err_clear(s_err_clear), .i_err_irq_mask(err_mask),
    .i_stat_clear(s_stat_clear), .o_link_start(s_link_start), .o_link_disable(s_link_disable),
    .o_chan_state(s_state), .o_retry_count(s_retry), .o_err_sticky(s_sticky),
    .o_link_down_cnt(s_cnt), .o_irq(s_irq)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2:0] st(input int ch);
    return chan_state[3*ch +: 3];
  endfunction

  function automatic logic [2:0] rc(input int ch);
    return retry_count[3*ch +: 3];
  endfunction

  function automatic logic [7:0] cnt(input int ch);
    return link_down_cnt[8*ch +: 8];
  endfunction

  function automatic logic [7:0] stk(input int ch);
    return err_sticky[8*ch +: 8];
  endfunction

  task automatic test_reset;
    rst = 1'b1;
    enable = '0; link_run = '0; err_status = '0; err_clear = '0;
    err_mask = '0; stat_clear = 1'b0;
    s_enable = 1'b0; s_run = 1'b0; s_stat_clear = 1'b0;
    s_err_status = '0; s_err_clear = '0;
    repeat (3) tick();
    rst = 1'b0;
    n_cmp++; if (link_disable !== 4'hF) begin n_err++; $display("FAIL reset_disable: got %h want f", link_disable); end
    n_cmp++; if (link_start !== 4'h0) begin n_err++; $display("FAIL reset_start: got %h want 0", link_start); end
    n_cmp++; if (chan_state !== 12'h000) begin n_err++; $display("FAIL reset_state: got %h want 000", chan_state); end
    n_cmp++; if (retry_count !== 12'h000) begin n_err++; $display("FAIL reset_retry: got %h want 000", retry_count); end
    n_cmp++; if (err_sticky !== 32'h0 || link_down_cnt !== 32'h0) begin n_err++; $display("FAIL reset_regs: sticky %h cnt %h want 0", err_sticky, link_down_cnt); end
    n_cmp++; if (irq !== 1'b0 || s_irq !== 1'b0) begin n_err++; $display("FAIL reset_irq: got %b/%b want 0", irq, s_irq); end
    n_cmp++; if (s_link_disable !== 1'b1 || s_state !== 3'd0) begin n_err++; $display("FAIL reset_sat: disable %b state %0d want 1/0", s_link_disable, s_state); end
  endtask

  task automatic test_start_run;
    enable[0] = 1'b1;
    tick();
    n_cmp++; if (st(0) !== 3'd1 || link_start[0] !== 1'b1) begin n_err++; $display("FAIL start_entry: state %0d start %b want 1/1", st(0), link_start[0]); end
    repeat (9) tick();
    n_cmp++; if (st(0) !== 3'd1) begin n_err++; $display("FAIL start_hold: state %0d want 1", st(0)); end
    link_run[0] = 1'b1;
    tick();
    n_cmp++; if (st(0) !== 3'd2) begin n_err++; $display("FAIL run_entry: state %0d want 2", st(0)); end
    n_cmp++; if (link_start[0] !== 1'b1 || link_disable[0] !== 1'b0) begin n_err++; $display("FAIL run_outputs: start %b disable %b want 1/0", link_start[0], link_disable[0]); end
    n_cmp++; if (rc(0) !== 3'd0) begin n_err++; $display("FAIL run_retry: got %0d want 0", rc(0)); end
  endtask

  task automatic test_timeout_failed;
    logic [2:0] ph_st [5];
    logic [2:0] ph_rc [5];
    int         ph_len[5];
    ph_st = '{3'd1, 3'd3, 3'd1, 3'd3, 3'd1};
    ph_rc = '{3'd0, 3'd1, 3'd1, 3'd2, 3'd2};
    ph_len = '{20, 8, 20, 16, 20};
    enable[1] = 1'b1;
    tick();
    for (int p = 0; p < 5; p++) begin
      for (int i = 0; i < ph_len[p]; i++) begin
        n_cmp++;
        if (st(1) !== ph_st[p] || rc(1) !== ph_rc[p]) begin
          n_err++;
          $display("FAIL timeout_seq phase %0d cycle %0d: state %0d retry %0d want %0d/%0d", p, i, st(1), rc(1), ph_st[p], ph_rc[p]);
        end
        tick();
      end
    end
    n_cmp++; if (st(1) !== 3'd4 || link_disable[1] !== 1'b1) begin n_err++; $display("FAIL failed_entry: state %0d disable %b want 4/1", st(1), link_disable[1]); end
    n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL failed_irq_lag: got %b want 0", irq); end
    n_cmp++; if (st(0) !== 3'd2) begin n_err++; $display("FAIL ch0_undisturbed: state %0d want 2", st(0)); end
    tick();
    n_cmp++; if (irq !== 1'b1) begin n_err++; $display("FAIL failed_irq: got %b want 1", irq); end
  endtask

  task automatic test_link_drop;
    link_run[2] = 1'b1;
    enable[2] = 1'b1;
    repeat (2) tick();
    n_cmp++; if (st(2) !== 3'd2 || rc(2) !== 3'd0) begin n_err++; $display("FAIL drop_pre_run: state %0d retry %0d want 2/0", st(2), rc(2)); end
    link_run[2] = 1'b0;
    tick();
    n_cmp++; if (cnt(2) !== 8'd1 || rc(2) !== 3'd1) begin n_err++; $display("FAIL drop_first: cnt %0d retry %0d want 1/1", cnt(2), rc(2)); end
    for (int i = 0; i < 8; i++) begin
      n_cmp++; if (st(2) !== 3'd3) begin n_err++; $display("FAIL drop_backoff cycle %0d: state %0d want 3", i, st(2)); end
      tick();
    end
    n_cmp++; if (st(2) !== 3'd1) begin n_err++; $display("FAIL drop_restart: state %0d want 1", st(2)); end
    link_run[2] = 1'b1;
    tick();
    for (int i = 0; i < 255; i++) begin
      link_run[2] = 1'b0;
      tick();
      repeat (8) tick();
      link_run[2] = 1'b1;
      tick();
    end
    n_cmp++; if (st(2) !== 3'd2 || cnt(2) !== 8'd255) begin n_err++; $display("FAIL drop_saturate: state %0d cnt %0d want 2/255", st(2), cnt(2)); end
    link_run[2] = 1'b0;
    stat_clear = 1'b1;
    tick();
    stat_clear = 1'b0;
    n_cmp++; if (cnt(2) !== 8'd1 || st(2) !== 3'd3) begin n_err++; $display("FAIL clear_with_drop: cnt %0d state %0d want 1/3", cnt(2), st(2)); end
    n_cmp++; if (cnt(0) !== 8'd0) begin n_err++; $display("FAIL ch0_cnt: got %0d want 0", cnt(0)); end
  endtask

  task automatic test_disable;
    enable[2] = 1'b0;
    tick();
    n_cmp++; if (st(2) !== 3'd0 || link_disable[2] !== 1'b1 || link_start[2] !== 1'b0) begin n_err++; $display("FAIL disable_backoff: state %0d disable %b start %b want 0/1/0", st(2), link_disable[2], link_start[2]); end
    enable[1] = 1'b0;
    tick();
    n_cmp++; if (st(1) !== 3'd0 || link_disable[1] !== 1'b1) begin n_err++; $display("FAIL disable_failed: state %0d disable %b want 0/1", st(1), link_disable[1]); end
    tick();
    n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL disable_irq: got %b want 0", irq); end
  endtask

  task automatic test_sticky;
    err_mask = 8'h10;
    err_status[31:24] = 8'h10;
    err_clear[31:24] = 8'h10;
    tick();
    err_status = '0;
    err_clear = '0;
    n_cmp++; if (stk(3) !== 8'h10 || irq !== 1'b0) begin n_err++; $display("FAIL sticky_set_wins: sticky %h irq %b want 10/0", stk(3), irq); end
    tick();
    n_cmp++; if (irq !== 1'b1 || stk(3) !== 8'h10) begin n_err++; $display("FAIL sticky_irq: irq %b sticky %h want 1/10", irq, stk(3)); end
    err_clear[31:24] = 8'h10;
    tick();
    err_clear = '0;
    n_cmp++; if (stk(3) !== 8'h00 || irq !== 1'b1) begin n_err++; $display("FAIL sticky_clear: sticky %h irq %b want 00/1", stk(3), irq); end
    tick();
    n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL sticky_irq_drop: got %b want 0", irq); end
    err_status[7:0] = 8'h01;
    tick();
    err_status = '0;
    n_cmp++; if (stk(0) !== 8'h01) begin n_err++; $display("FAIL sticky_unmasked: got %h want 01", stk(0)); end
    repeat (2) tick();
    n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL masked_irq: got %b want 0", irq); end
    err_clear[7:0] = 8'h01;
    tick();
    err_clear = '0;
    n_cmp++; if (stk(0) !== 8'h00) begin n_err++; $display("FAIL sticky_clear0: got %h want 00", stk(0)); end
  endtask

  task automatic test_reset_mid_run;
    enable = 4'hF;
    link_run = 4'hF;
    err_mask = 8'h01;
    err_status[15:8] = 8'h01;
    repeat (2) tick();
    err_status = '0;
    n_cmp++; if (chan_state !== 12'h492) begin n_err++; $display("FAIL all_run: got %h want 492", chan_state); end
    tick();
    n_cmp++; if (irq !== 1'b1) begin n_err++; $display("FAIL pre_reset_irq: got %b want 1", irq); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++; if (chan_state !== 12'h000 || link_disable !== 4'hF || link_start !== 4'h0) begin n_err++; $display("FAIL midrun_reset_state: state %h disable %h start %h want 000/f/0", chan_state, link_disable, link_start); end
    n_cmp++; if (err_sticky !== 32'h0 || link_down_cnt !== 32'h0 || retry_count !== 12'h0 || irq !== 1'b0) begin n_err++; $display("FAIL midrun_reset_regs: sticky %h cnt %h retry %h irq %b want 0", err_sticky, link_down_cnt, retry_count, irq); end
    enable = '0;
    link_run = '0;
    err_mask = '0;
    tick();
  endtask

  task automatic test_backoff_sat;
    logic [2:0] ph_st [7];
    logic [2:0] ph_rc [7];
    int         ph_len[7];
    ph_st = '{3'd1, 3'd3, 3'd1, 3'd3, 3'd1, 3'd3, 3'd1};
    ph_rc = '{3'd0, 3'd1, 3'd1, 3'd2, 3'd2, 3'd3, 3'd3};
    ph_len = '{4, 100, 4, 200, 4, 255, 4};
    s_enable = 1'b1;
    tick();
    for (int p = 0; p < 7; p++) begin
      for (int i = 0; i < ph_len[p]; i++) begin
        n_cmp++;
        if (s_state !== ph_st[p] || s_retry !== ph_rc[p]) begin
          n_err++;
          $display("FAIL sat_seq phase %0d cycle %0d: state %0d retry %0d want %0d/%0d", p, i, s_state, s_retry, ph_st[p], ph_rc[p]);
        end
        tick();
      end
    end
    n_cmp++; if (s_state !== 3'd4) begin n_err++; $display("FAIL sat_failed: state %0d want 4", s_state); end
    tick();
    n_cmp++; if (s_irq !== 1'b1) begin n_err++; $display("FAIL sat_irq: got %b want 1", s_irq); end
    s_enable = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_start_run();
    test_timeout_failed();
    test_link_drop();
    test_disable();
    test_sticky();
    test_reset_mid_run();
    test_backoff_sat();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
